// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths, fetch FSM encoding and
// the default boot address.
package mips_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 6;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; low bits of a target are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold under stall, flush on redirect, and
// retire the slot when decode consumes it with nothing new behind it.
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic            stall,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc4,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end else if (valid && !stall) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding request at a time, parks a
// response in a skid register while decode stalls, and drains redirects safely.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_instr,
    output logic [OPCODE_W-1:0] if_opcode,
    output logic [XLEN-1:0]     if_pc_plus4,
    output logic [1:0]          fetch_state
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_pc, pend_pc_n;
    logic [XLEN-1:0] skid_instr, skid_instr_n;
    logic [XLEN-1:0] skid_pc4, skid_pc4_n;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic            slot_free;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] load_pc4;

    assign pc_plus4    = pc + 32'd4;
    assign target      = word_align(redirect_pc);
    assign slot_free   = !if_valid || !stall;
    assign imem_req    = (state == FETCH) || (state == DROP);
    assign imem_addr   = pc;
    assign if_opcode   = if_instr[XLEN-1 -: OPCODE_W];
    assign fetch_state = state;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_pc_n    = pend_pc;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        load         = 1'b0;
        load_instr   = imem_rdata;
        load_pc4     = pc_plus4;
        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect) pc_n = target;
            end
            FETCH: begin
                if (redirect) begin
                    // A request already on the bus must complete before the new target is issued.
                    if (imem_ready) begin
                        pc_n = target;
                    end else begin
                        pend_pc_n = target;
                        state_n   = DROP;
                    end
                end else if (imem_ready) begin
                    pc_n = pc_plus4;
                    if (slot_free) begin
                        load = 1'b1;
                    end else begin
                        skid_instr_n = imem_rdata;
                        skid_pc4_n   = pc_plus4;
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = skid_instr;
                    load_pc4   = skid_pc4;
                    state_n    = FETCH;
                end
            end
            DROP: begin
                if (redirect) pend_pc_n = target;
                if (imem_ready) begin
                    pc_n    = redirect ? target : pend_pc;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
        if (redirect) begin
            skid_instr_n = '0;
            skid_pc4_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_pc    <= pend_pc_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .flush      (redirect),
        .stall      (stall),
        .load_instr (load_instr),
        .load_pc4   (load_pc4),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc4        (if_pc_plus4)
    );

endmodule
